// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: opcode set, instruction
// field positions and the fetch-stage state encoding.
package proc_pkg;

  localparam int unsigned PC_W_DEF    = 8;
  localparam int unsigned INSTR_W_DEF = 16;

  // ALU opcode set plus the two control-flow opcodes handled by fetch
  localparam logic [3:0] OP_SAIDA   = 4'b0000;
  localparam logic [3:0] OP_ENTRADA = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SUB     = 4'b0011;
  localparam logic [3:0] OP_AND     = 4'b0100;
  localparam logic [3:0] OP_OR      = 4'b0101;
  localparam logic [3:0] OP_XOR     = 4'b0110;
  localparam logic [3:0] OP_NOT     = 4'b0111;
  localparam logic [3:0] OP_SHL     = 4'b1000;
  localparam logic [3:0] OP_SHR     = 4'b1001;
  localparam logic [3:0] OP_LDI     = 4'b1010;
  localparam logic [3:0] OP_MOV     = 4'b1011;
  localparam logic [3:0] OP_JMP     = 4'b1100;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned OPA_HI = 11;
  localparam int unsigned OPA_LO = 8;
  localparam int unsigned OPB_HI = 7;
  localparam int unsigned OPB_LO = 4;
  localparam int unsigned IMM_HI = 3;
  localparam int unsigned IMM_LO = 0;
  localparam int unsigned TGT_HI = 7;
  localparam int unsigned TGT_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W_DEF-1:0] i);
    return i[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [3:0] instr_op_a(input logic [INSTR_W_DEF-1:0] i);
    return i[OPA_HI:OPA_LO];
  endfunction

  function automatic logic [3:0] instr_op_b(input logic [INSTR_W_DEF-1:0] i);
    return i[OPB_HI:OPB_LO];
  endfunction

  function automatic logic [3:0] instr_imm(input logic [INSTR_W_DEF-1:0] i);
    return i[IMM_HI:IMM_LO];
  endfunction

  function automatic logic [7:0] instr_target(input logic [INSTR_W_DEF-1:0] i);
    return i[TGT_HI:TGT_LO];
  endfunction

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction memory bus: the fetch stage drives address and read strobe,
// the synchronous memory answers with data one cycle after the strobe.
interface busca_instrucao_if
  import proc_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
);

  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_addr,
    output imem_rd,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_rd,
    output imem_data
  );

endinterface

// File: rtl/busca_instrucao_contador_programa.sv
// Program counter register: hold by default, load has priority over
// increment, increment wraps modulo 2^PC_W.
module contador_programa #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_ONE;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: PC, instruction register and the
// IDLE/FETCH/WAIT/ISSUE/HALT sequencer feeding the control unit.
module busca_instrucao
  import proc_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stall,
  busca_instrucao_if.master imem,
  output logic [3:0]        opcode,
  output logic [3:0]        op_a,
  output logic [3:0]        op_b,
  output logic [3:0]        imm,
  output logic              instr_valid,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               ir_load;
  logic               pc_inc;
  logic               pc_load;
  logic [7:0]         jmp_full;
  logic [PC_W-1:0]    jmp_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (ir_load) begin
      ir <= imem.imem_data;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        ir_load   = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // Opcodes 1101/1110 fall through to the sequential path
        if (!stall) begin
          if (opcode == OP_HALT) begin
            state_nxt = S_HALT;
          end else if (opcode == OP_JMP) begin
            pc_load   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign jmp_full   = instr_target(ir);
  assign jmp_target = jmp_full[PC_W-1:0];

  contador_programa #(
    .PC_W (PC_W)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (jmp_target),
    .pc       (pc)
  );

  // Every output decodes from state, IR or PC only
  assign opcode         = instr_opcode(ir);
  assign op_a           = instr_op_a(ir);
  assign op_b           = instr_op_b(ir);
  assign imm            = instr_imm(ir);
  assign instr_valid    = (state == S_ISSUE);
  assign halted         = (state == S_HALT);
  assign imem.imem_rd   = (state == S_FETCH);
  assign imem.imem_addr = pc;

endmodule
